// File: rtl/ap_ctrl_chain_sequencer_if.sv
// Shared clock/reset bundle: rising-edge clock, asynchronous active-high reset.
interface clkrst_if;
   logic clk;
   logic rst;

   modport sink (input clk, input rst);
endinterface

// File: rtl/ap_ctrl_chain_sequencer.sv
// Drives an HLS kernel's ap_ctrl_chain handshake for a programmed number of transactions,
// bounding in-flight work, counting starts/dones and flagging count mismatch, hangs and protocol errors.
module ap_ctrl_chain_sequencer #(
   parameter int CNT_W           = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_W       = 20
) (
   clkrst_if.sink            clkrst_if,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [CNT_W-1:0]  cfg_num_trans,
   input  logic [CNT_W-1:0]  cfg_ref_cnt,
   input  logic              cfg_ref_chk_en,
   input  logic              cfg_auto_continue,
   input  logic              sw_continue,
   output logic              ap_start,
   input  logic              ap_ready,
   input  logic              ap_done,
   input  logic              ap_idle,
   output logic              ap_continue,
   output logic              busy,
   output logic              finish,
   output logic [CNT_W-1:0]  trans_cnt,
   output logic [CNT_W-1:0]  done_cnt,
   output logic              cnt_mismatch,
   output logic              timeout,
   output logic              protocol_err,
   output logic [2:0]        state_o
);

   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_DRAIN  = 3'd2,
      S_FINISH = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_num, w_num_nxt;
   logic [CNT_W-1:0]     r_ref, w_ref_nxt;
   logic                 r_chk_en, w_chk_en_nxt;
   logic [CNT_W-1:0]     r_trans_cnt, w_trans_nxt;
   logic [CNT_W-1:0]     r_done_cnt, w_done_nxt;
   logic [OUT_W-1:0]     r_outstanding, w_out_nxt;
   logic [TIMEOUT_W-1:0] r_wdog, w_wdog_nxt;
   logic                 r_ap_start, w_ap_start_nxt;
   logic                 r_ap_continue, w_ap_cont_nxt;
   logic                 r_busy;
   logic                 r_finish, w_finish_nxt;
   logic                 r_cnt_mismatch, w_mismatch_nxt;
   logic                 r_timeout, w_timeout_nxt;
   logic                 r_protocol_err, w_perr_nxt;
   logic                 w_start_acc, w_done_acc;

   assign w_start_acc = r_ap_start & ap_ready;
   assign w_done_acc  = r_ap_continue & ap_done;

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_nxt    = r_state;
      w_num_nxt      = r_num;
      w_ref_nxt      = r_ref;
      w_chk_en_nxt   = r_chk_en;
      w_trans_nxt    = r_trans_cnt;
      w_done_nxt     = r_done_cnt;
      w_out_nxt      = r_outstanding;
      w_wdog_nxt     = '0;
      w_ap_start_nxt = 1'b0;
      w_ap_cont_nxt  = 1'b0;
      w_finish_nxt   = 1'b0;
      w_mismatch_nxt = r_cnt_mismatch;
      w_timeout_nxt  = r_timeout;
      w_perr_nxt     = r_protocol_err;

      if (cfg_abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  w_num_nxt      = cfg_num_trans;
                  w_ref_nxt      = cfg_ref_cnt;
                  w_chk_en_nxt   = cfg_ref_chk_en;
                  w_trans_nxt    = '0;
                  w_done_nxt     = '0;
                  w_out_nxt      = '0;
                  w_mismatch_nxt = 1'b0;
                  w_timeout_nxt  = 1'b0;
                  w_perr_nxt     = 1'b0;
                  if (cfg_num_trans == '0) begin
                     w_state_nxt = S_FINISH;
                  end else begin
                     w_state_nxt    = S_ISSUE;
                     w_ap_start_nxt = 1'b1;
                  end
               end
            end
            S_ISSUE, S_DRAIN: begin
               w_trans_nxt   = r_trans_cnt + CNT_W'(w_start_acc);
               w_done_nxt    = r_done_cnt + CNT_W'(w_done_acc);
               w_out_nxt     = r_outstanding + OUT_W'(w_start_acc) - OUT_W'(w_done_acc);
               w_wdog_nxt    = (w_start_acc || w_done_acc) ? '0 : r_wdog + TIMEOUT_W'(1);
               // Continue is a single-cycle pulse, so a back-to-back done waits one idle cycle.
               w_ap_cont_nxt = ap_done && (r_outstanding != '0) && !r_ap_continue &&
                               (cfg_auto_continue || sw_continue);
               if (r_state == S_ISSUE) begin
                  w_ap_start_nxt = (w_trans_nxt < r_num) && (w_out_nxt < MAX_OUT);
                  if (w_trans_nxt == r_num) begin
                     w_state_nxt = S_DRAIN;
                  end
               end else if ((r_outstanding == '0) && ap_idle) begin
                  w_state_nxt = S_FINISH;
               end
               if (!(w_start_acc || w_done_acc) && (&r_wdog)) begin
                  w_state_nxt    = S_ERR;
                  w_timeout_nxt  = 1'b1;
                  w_ap_start_nxt = 1'b0;
                  w_ap_cont_nxt  = 1'b0;
               end
            end
            S_FINISH: begin
               w_finish_nxt = 1'b1;
               if (r_chk_en && (r_trans_cnt != r_ref)) begin
                  w_mismatch_nxt = 1'b1;
               end
               w_state_nxt = S_IDLE;
            end
            S_ERR: begin
               w_state_nxt = S_ERR;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end

      if ((ap_done && (r_outstanding == '0)) || (ap_ready && !r_ap_start)) begin
         w_perr_nxt = 1'b1;
      end
   end

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clkrst_if.clk or posedge clkrst_if.rst) begin
      if (clkrst_if.rst) begin
         r_state        <= S_IDLE;
         r_num          <= '0;
         r_ref          <= '0;
         r_chk_en       <= 1'b0;
         r_trans_cnt    <= '0;
         r_done_cnt     <= '0;
         r_outstanding  <= '0;
         r_wdog         <= '0;
         r_ap_start     <= 1'b0;
         r_ap_continue  <= 1'b0;
         r_busy         <= 1'b0;
         r_finish       <= 1'b0;
         r_cnt_mismatch <= 1'b0;
         r_timeout      <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_num          <= w_num_nxt;
         r_ref          <= w_ref_nxt;
         r_chk_en       <= w_chk_en_nxt;
         r_trans_cnt    <= w_trans_nxt;
         r_done_cnt     <= w_done_nxt;
         r_outstanding  <= w_out_nxt;
         r_wdog         <= w_wdog_nxt;
         r_ap_start     <= w_ap_start_nxt;
         r_ap_continue  <= w_ap_cont_nxt;
         r_busy         <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
         r_finish       <= w_finish_nxt;
         r_cnt_mismatch <= w_mismatch_nxt;
         r_timeout      <= w_timeout_nxt;
         r_protocol_err <= w_perr_nxt;
      end
   end

   assign ap_start     = r_ap_start;
   assign ap_continue  = r_ap_continue;
   assign busy         = r_busy;
   assign finish       = r_finish;
   assign trans_cnt    = r_trans_cnt;
   assign done_cnt     = r_done_cnt;
   assign cnt_mismatch = r_cnt_mismatch;
   assign timeout      = r_timeout;
   assign protocol_err = r_protocol_err;
   assign state_o      = r_state;

endmodule

// File: tb/tb_ap_ctrl_chain_sequencer.sv
// Scoreboard bench: a randomized kernel model answers the handshake, runs push expected results,
// and a monitor compares them when finish pulses, plus per-handshake counter tracking.
module tb_ap_ctrl_chain_sequencer;

   localparam int CNT_W     = 32;
   localparam int MAX_OUT   = 2;
   localparam int TIMEOUT_W = 6;

   typedef struct {
      int unsigned num;
      logic        mismatch;
      logic        perr;
   } exp_t;

   logic clk, rst;
   logic cfg_start, cfg_abort, cfg_ref_chk_en, cfg_auto_continue, sw_continue;
   logic [CNT_W-1:0] cfg_num_trans, cfg_ref_cnt;
   logic ap_start, ap_ready, ap_done, ap_idle, ap_continue;
   logic busy, finish, cnt_mismatch, timeout, protocol_err;
   logic [CNT_W-1:0] trans_cnt, done_cnt;
   logic [2:0] state_o;

   clkrst_if u_clkrst ();
   assign u_clkrst.clk = clk;
   assign u_clkrst.rst = rst;

   ap_ctrl_chain_sequencer #(
      .CNT_W(CNT_W), .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clkrst_if(u_clkrst),
      .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_num_trans(cfg_num_trans), .cfg_ref_cnt(cfg_ref_cnt),
      .cfg_ref_chk_en(cfg_ref_chk_en), .cfg_auto_continue(cfg_auto_continue),
      .sw_continue(sw_continue),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
      .ap_continue(ap_continue),
      .busy(busy), .finish(finish), .trans_cnt(trans_cnt), .done_cnt(done_cnt),
      .cnt_mismatch(cnt_mismatch), .timeout(timeout), .protocol_err(protocol_err),
      .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks, n_pass, coinc;
   exp_t exp_q[$];
   int   k_mode;      // 0 normal, 1 never ready, 2 manual done
   logic k_force_done;
   int   k_rmin, k_rmax, k_dmin, k_dmax;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Kernel: ready after a random wait once ap_start is seen; each accepted start completes
   // after a random latency; dones are presented in order and held until continued.
   initial begin
      int   pend[$];
      int   rdy_wait;
      logic st, sa, da;
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      ap_idle  = 1'b1;
      rdy_wait = 0;
      forever begin
         @(negedge clk);
         st = ap_start;
         sa = ap_start & ap_ready;
         da = ap_done & ap_continue;
         @(posedge clk);
         #1;
         if (rst) begin
            pend.delete();
            ap_ready = 1'b0;
            ap_done  = 1'b0;
            ap_idle  = 1'b1;
         end else if (k_mode == 2) begin
            ap_done = k_force_done;
         end else begin
            if (da) begin
               ap_done = 1'b0;
               void'(pend.pop_front());
            end
            foreach (pend[i]) if (pend[i] > 0) pend[i]--;
            if (sa) begin
               ap_ready = 1'b0;
               pend.push_back(int'($urandom_range(k_dmax, k_dmin)));
               rdy_wait = int'($urandom_range(k_rmax, k_rmin));
            end else if (st && !ap_ready && k_mode == 0) begin
               if (rdy_wait == 0) ap_ready = 1'b1;
               else rdy_wait--;
            end
            if (!ap_done && pend.size() > 0 && pend[0] == 0) ap_done = 1'b1;
            ap_idle = (pend.size() == 0);
         end
      end
   end

   // Monitor: tracks handshakes seen on the ports and scores each finish against the queue.
   initial begin
      int unsigned m_starts, m_dones, m_conts;
      bit   pend_cmp;
      exp_t e;
      m_starts = 0; m_dones = 0; m_conts = 0; pend_cmp = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_starts = 0; m_dones = 0; m_conts = 0; pend_cmp = 0;
            continue;
         end
         if (pend_cmp) begin
            check("trans_cnt_track", trans_cnt, m_starts);
            check("done_cnt_track", done_cnt, m_dones);
            pend_cmp = 0;
         end
         if (ap_continue) m_conts++;
         if (ap_start) check("inflight_limit", ((m_starts - m_dones) < MAX_OUT), 1);
         if (finish) begin
            if (exp_q.size() == 0) begin
               check("unexpected_finish", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("fin_trans_cnt", trans_cnt, e.num);
               check("fin_done_cnt", done_cnt, e.num);
               check("fin_continues", m_conts, e.num);
               check("fin_mismatch", cnt_mismatch, e.mismatch);
               check("fin_protocol_err", protocol_err, e.perr);
               check("fin_timeout", timeout, 0);
            end
         end
         if (cfg_start && !cfg_abort) begin
            m_starts = 0; m_dones = 0; m_conts = 0; pend_cmp = 1;
         end
         if (ap_start && ap_ready) begin
            m_starts++;
            pend_cmp = 1;
         end
         if (ap_done && ap_continue) begin
            m_dones++;
            pend_cmp = 1;
            if (ap_start && ap_ready) coinc++;
         end
      end
   end

   task automatic pulse_start(input int unsigned num, input int unsigned ref_v, input logic chk);
      cfg_num_trans  = num;
      cfg_ref_cnt    = ref_v;
      cfg_ref_chk_en = chk;
      cfg_start      = 1'b1;
      tick(1);
      cfg_start      = 1'b0;
   endtask

   task automatic wait_finish(input int budget, input logic rnd_sw, output int lat);
      bit seen;
      seen = 0;
      lat  = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (finish) begin
            seen = 1;
            lat  = i;
            break;
         end
         tick(1);
         if (rnd_sw) sw_continue = 1'($urandom_range(1, 0));
      end
      if (!seen) check("finish_timeout", 0, 1);
      tick(1);
      sw_continue = 1'b0;
   endtask

   task automatic run(input int unsigned num, input int unsigned ref_v, input logic chk,
                      input logic rnd_sw, output int lat);
      exp_t e;
      e.num      = num;
      e.mismatch = chk && (ref_v != num);
      e.perr     = 1'b0;
      exp_q.push_back(e);
      pulse_start(num, ref_v, chk);
      wait_finish(400, rnd_sw, lat);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int          lat, cyc, last_num, conts;
      int unsigned num, ref_v;
      logic        chk, auto_c;
      bit          seen;
      n_checks = 0; n_pass = 0; coinc = 0;
      k_mode = 0; k_force_done = 1'b0;
      k_rmin = 0; k_rmax = 0; k_dmin = 4; k_dmax = 4;
      cfg_start = 0; cfg_abort = 0; cfg_ref_chk_en = 0; cfg_auto_continue = 1;
      sw_continue = 0; cfg_num_trans = '0; cfg_ref_cnt = '0;
      rst = 1'b1;
      tick(3);
      check("rst_state", state_o, 0);
      check("rst_outputs", {ap_start, ap_continue, busy, finish, cnt_mismatch, timeout, protocol_err}, 0);
      check("rst_trans_cnt", trans_cnt, 0);
      check("rst_done_cnt", done_cnt, 0);
      rst = 1'b0;
      tick(2);

      // T1: 3 transactions, ready 1 cycle after start, done 4 cycles later
      run(3, 3, 1'b1, 1'b0, lat);
      // T5: count mismatch, then empty run
      run(2, 3, 1'b1, 1'b0, lat);
      run(0, 0, 1'b1, 1'b0, lat);
      check("zero_run_finish_latency", lat, 2);

      // T4: manual continue held off for 10 cycles
      cfg_auto_continue = 1'b0;
      begin
         exp_t e;
         e.num = 1; e.mismatch = 1'b0; e.perr = 1'b0;
         exp_q.push_back(e);
      end
      pulse_start(1, 1, 1'b0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ap_done) begin
            seen = 1;
            break;
         end
         tick(1);
      end
      check("t4_done_seen", seen, 1);
      tick(1);
      conts = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ap_continue) conts++;
         tick(1);
      end
      check("t4_no_continue", conts, 0);
      check("t4_done_cnt_held", done_cnt, 0);
      sw_continue = 1'b1;
      wait_finish(100, 1'b0, lat);
      cfg_auto_continue = 1'b1;

      // Randomized runs
      k_rmin = 0; k_rmax = 2; k_dmin = 1; k_dmax = 6;
      last_num = 0;
      for (int r = 0; r < 20; r++) begin
         num    = $urandom_range(6, 1);
         ref_v  = num + $urandom_range(2, 0) - 1;
         chk    = 1'($urandom_range(1, 0));
         auto_c = 1'($urandom_range(1, 0));
         cfg_auto_continue = auto_c;
         run(num, ref_v, chk, !auto_c, lat);
         last_num = int'(num);
      end
      cfg_auto_continue = 1'b1;

      // T6: spurious done while idle
      k_mode = 2;
      k_force_done = 1'b1;
      seen = 0;
      conts = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ap_continue) conts++;
         if (protocol_err) begin
            seen = 1;
            break;
         end
         tick(1);
      end
      check("t6_protocol_err", seen, 1);
      check("t6_no_continue", conts, 0);
      check("t6_done_cnt_unchanged", done_cnt, last_num);
      tick(1);
      k_force_done = 1'b0;
      tick(3);
      k_mode = 0;

      // T2: kernel never accepts -> watchdog
      k_mode = 1;
      pulse_start(5, 5, 1'b0);
      cyc = 0;
      seen = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (state_o == 3'd4) begin
            seen = 1;
            cyc  = i;
            break;
         end
         tick(1);
      end
      check("t2_reached_err", seen, 1);
      check("t2_wdog_latency", (cyc >= 63 && cyc <= 65), 1);
      check("t2_timeout_flag", timeout, 1);
      check("t2_ap_start_low", ap_start, 0);
      tick(1);
      cfg_abort = 1'b1;
      tick(1);
      cfg_abort = 1'b0;
      @(negedge clk);
      check("t2_abort_idle", state_o, 0);
      check("t2_timeout_sticky", timeout, 1);
      tick(1);
      k_mode = 0;

      // abort wins over a simultaneous start
      cfg_num_trans = 4;
      cfg_start = 1'b1;
      cfg_abort = 1'b1;
      tick(1);
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      @(negedge clk);
      check("abort_wins_state", state_o, 0);
      check("abort_wins_ap_start", ap_start, 0);
      check("abort_wins_flags_kept", timeout, 1);
      tick(1);

      // reset in the middle of a run
      pulse_start(6, 6, 1'b0);
      tick(4);
      rst = 1'b1;
      #1;
      check("midrun_rst_state", state_o, 0);
      check("midrun_rst_outputs", {ap_start, ap_continue, busy, finish, cnt_mismatch, timeout, protocol_err}, 0);
      check("midrun_rst_trans_cnt", trans_cnt, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // recovery run after reset
      run(2, 2, 1'b1, 1'b0, lat);

      tick(3);
      check("scoreboard_empty", exp_q.size(), 0);
      check("coincident_accepts_seen", (coinc > 0), 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
